gerador_eco: RTL and testbench

Emulator of the ultrasonic sensor's echo side. It is the responder that produces the pulse the sonar distance counter measures. On a trigger it latches a 3-digit BCD distance, waits a fixed response delay, then drives `echo` high for exactly distance × R clocks. The block sits in the sonar test harness and FPGA self-test path in place of the physical sensor, so the measurement chain can be exercised with known distances.

---
 rtl/gerador_eco.sv | 156 +++++++++++++++
 tb/tb_gerador_eco.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/gerador_eco.sv
// gerador_eco: ultrasonic-sensor echo emulator.
// On a trigger rising edge the block latches a 3-digit BCD distance, waits D
// clocks, then drives echo high for distance x R clocks and pulses pronto once.
// Optional feature macro: GERADOR_ECO_BCD_CHECK_EN (rejects non-BCD digits and
// reports them on erro; without it erro is tied low).
module gerador_eco #(
   parameter int R  = 10,
   parameter int N  = 4,
   parameter int D  = 100,
   parameter int ND = 7
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       trigger,
   input  logic [3:0] digito0,
   input  logic [3:0] digito1,
   input  logic [3:0] digito2,
   output logic       echo,
   output logic       pronto,
   output logic       erro,
   output logic [2:0] db_estado
);

   typedef enum logic [2:0] {
      INICIAL    = 3'b000,
      PREPARACAO = 3'b001,
      ESPERA     = 3'b010,
      ECO        = 3'b011,
      FIM        = 3'b100,
      ERRO       = 3'b101
   } estado_t;

   estado_t        estado_q, estado_d;
   logic           trigger_q, trigger_d;
   logic           armado_q, armado_d;
   logic [11:0]    bcd_q, bcd_d;
   logic [ND-1:0]  atraso_q, atraso_d;
   logic [N-1:0]   tick_q, tick_d;
   logic           borda;

   // Decrement a 3-digit BCD value by one, borrowing 0 -> 9 into the next digit.
   // Non-BCD nibbles simply lose one, so out-of-range digits still count down.
   function automatic logic [11:0] bcd_dec(input logic [11:0] v);
      logic [11:0] r;
      logic        b;
      r = v;
      b = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (b) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               b = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // armado_q only rises once trigger has been seen low after reset, so a
   // trigger already high when reset is released is not taken as an edge.
   assign borda     = trigger & ~trigger_q & armado_q;
   assign trigger_d = trigger;
   assign armado_d  = armado_q | ~trigger;

   // Next-state and counter logic.  The BCD counter is decremented once when
   // echo starts so that the exit test (counter 000, tick R-1) lands exactly
   // on the last of the V*R echo cycles.
   always_comb begin
      estado_d = estado_q;
      bcd_d    = bcd_q;
      atraso_d = atraso_q;
      tick_d   = tick_q;
      case (estado_q)
         INICIAL: begin
            if (borda) estado_d = PREPARACAO;
         end
         PREPARACAO: begin
            bcd_d    = {digito2, digito1, digito0};
            atraso_d = '0;
            tick_d   = '0;
`ifdef GERADOR_ECO_BCD_CHECK_EN
            if ((digito0 > 4'd9) || (digito1 > 4'd9) || (digito2 > 4'd9))
               estado_d = ERRO;
            else
               estado_d = ESPERA;
`else
            estado_d = ESPERA;
`endif
         end
         ESPERA: begin
            if (atraso_q == ND'(D - 1)) begin
               if (bcd_q == 12'h000) begin
                  estado_d = FIM;
               end else begin
                  estado_d = ECO;
                  bcd_d    = bcd_dec(bcd_q);
               end
            end else begin
               atraso_d = atraso_q + 1'b1;
            end
         end
         ECO: begin
            if (tick_q == N'(R - 1)) begin
               tick_d = '0;
               if (bcd_q == 12'h000) estado_d = FIM;
               else                  bcd_d    = bcd_dec(bcd_q);
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
         FIM: begin
            estado_d = INICIAL;
         end
`ifdef GERADOR_ECO_BCD_CHECK_EN
         ERRO: begin
            if (borda) estado_d = PREPARACAO;
         end
`endif
         default: begin
            estado_d = INICIAL;
         end
      endcase
   end

   // State, edge-detect and counter registers with asynchronous active-low reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q  <= INICIAL;
         trigger_q <= 1'b0;
         armado_q  <= 1'b0;
         bcd_q     <= '0;
         atraso_q  <= '0;
         tick_q    <= '0;
      end else begin
         estado_q  <= estado_d;
         trigger_q <= trigger_d;
         armado_q  <= armado_d;
         bcd_q     <= bcd_d;
         atraso_q  <= atraso_d;
         tick_q    <= tick_d;
      end
   end

   // Outputs are pure decodes of the registered state, so reset drops echo at once.
   assign echo      = (estado_q == ECO);
   assign pronto    = (estado_q == FIM);
   assign db_estado = estado_q;
`ifdef GERADOR_ECO_BCD_CHECK_EN
   assign erro      = (estado_q == ERRO);
`else
   assign erro      = 1'b0;
`endif

endmodule

// File: tb/tb_gerador_eco.sv
// Directed, table-driven bench for gerador_eco with R=4, D=5.
module tb_gerador_eco;

   localparam int R  = 4;
   localparam int N  = 2;
   localparam int D  = 5;
   localparam int ND = 3;

   logic       clock = 1'b0;
   logic       reset;
   logic       trigger;
   logic [3:0] d0, d1, d2;
   logic       echo, pronto, erro;
   logic [2:0] db_estado;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [3:0] d2;
      logic [3:0] d1;
      logic [3:0] d0;
      int         largura;
   } vetor_t;

   vetor_t tab [6];

   gerador_eco #(.R(R), .N(N), .D(D), .ND(ND)) dut (
      .clock     (clock),
      .reset     (reset),
      .trigger   (trigger),
      .digito0   (d0),
      .digito1   (d1),
      .digito2   (d2),
      .echo      (echo),
      .pronto    (pronto),
      .erro      (erro),
      .db_estado (db_estado)
   );

   always #5 clock = ~clock;

   task automatic check(input string nome, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nome, act, exp);
      end
   endtask

   // Fire one trigger (high for 3 cycles) with the given digits and observe the
   // whole transaction; n counts negedges after the posedge that samples the edge.
   task automatic run_pulse(input logic [3:0] a2, input logic [3:0] a1, input logic [3:0] a0,
                            input int largura, input bit perturba, input int cauda);
      int subida   = -1;
      int fim_n    = -1;
      int nalto    = 0;
      int n_pronto = 0;
      d2 = a2; d1 = a1; d0 = a0;
      trigger = 1'b1;
      for (int n = 1; n <= largura + D + 40; n++) begin
         @(negedge clock);
         if (n == 1) check("estado_prep", int'(db_estado), 1);
         if (n == 2) check("estado_espera", int'(db_estado), 2);
         if (echo) begin
            if (subida < 0) begin
               subida = n;
               check("estado_eco", int'(db_estado), 3);
            end
            nalto++;
         end
         if (pronto) begin
            n_pronto++;
            if (fim_n < 0) begin
               fim_n = n;
               check("estado_fim", int'(db_estado), 4);
               check("erro_baixo", int'(erro), 0);
            end
         end
         if (fim_n >= 0 && n == fim_n + 1) check("estado_volta", int'(db_estado), 0);
         if (n == 3) trigger = 1'b0;
         if (perturba) begin
            if (n == 20) trigger = 1'b1;
            if (n == 22) trigger = 1'b0;
            if (n == 24) begin d2 = 4'd9; d1 = 4'd9; d0 = 4'd9; end
         end
         if (fim_n >= 0 && n >= fim_n + cauda) break;
      end
      check("pronto_visto", int'(fim_n >= 0), 1);
      if (largura > 0) check("latencia_eco", subida, D + 2);
      check("largura_eco", nalto, largura);
      check("pronto_ciclo", fim_n, D + 2 + largura);
      check("n_pronto", n_pronto, 1);
   endtask

   initial begin
      int altos;
      int nao_zero;
      tab[0] = '{4'd3, 4'd4, 4'd5, 345 * R};
      tab[1] = '{4'd0, 4'd1, 4'd0, 10 * R};
      tab[2] = '{4'd1, 4'd0, 4'd0, 100 * R};
      tab[3] = '{4'd0, 4'd0, 4'd1, 1 * R};
      tab[4] = '{4'd9, 4'd9, 4'd9, 999 * R};
      tab[5] = '{4'd2, 4'd0, 4'd7, 207 * R};

      reset = 1'b0; trigger = 1'b0; d0 = 4'd0; d1 = 4'd0; d2 = 4'd0;
      #12;
      check("rst_echo", int'(echo), 0);
      check("rst_pronto", int'(pronto), 0);
      check("rst_erro", int'(erro), 0);
      check("rst_estado", int'(db_estado), 0);
      @(negedge clock);
      reset = 1'b1;
      repeat (3) @(negedge clock);

      for (int i = 0; i < 6; i++) begin
         run_pulse(tab[i].d2, tab[i].d1, tab[i].d0, tab[i].largura, 1'b0, 3);
         @(negedge clock);
      end

      // Distance 000, then a new trigger two cycles after pronto.
      run_pulse(4'd0, 4'd0, 4'd0, 0, 1'b0, 1);
      run_pulse(4'd0, 4'd1, 4'd0, 10 * R, 1'b0, 3);

      // Re-trigger and digit changes during echo must not disturb the pulse.
      run_pulse(4'd3, 4'd4, 4'd5, 345 * R, 1'b1, 15);
      @(negedge clock);

      // Reset in the middle of echo, with trigger held high across release.
      d2 = 4'd3; d1 = 4'd4; d0 = 4'd5;
      trigger = 1'b1;
      repeat (D + 2 + 600) @(negedge clock);
      check("eco_antes_reset", int'(echo), 1);
      #2 reset = 1'b0;
      #1;
      check("reset_eco_cai", int'(echo), 0);
      check("reset_estado", int'(db_estado), 0);
      @(negedge clock);
      reset = 1'b1;
      altos = 0;
      nao_zero = 0;
      for (int n = 0; n < 30; n++) begin
         @(negedge clock);
         if (echo) altos++;
         if (db_estado != 3'b000) nao_zero++;
      end
      check("pos_reset_sem_eco", altos, 0);
      check("pos_reset_ocioso", nao_zero, 0);
      trigger = 1'b0;
      @(negedge clock);
      run_pulse(4'd0, 4'd0, 4'd2, 2 * R, 1'b0, 3);

`ifdef GERADOR_ECO_BCD_CHECK_EN
      d2 = 4'd0; d1 = 4'd0; d0 = 4'hA;
      trigger = 1'b1;
      @(negedge clock);
      check("bcd_prep", int'(db_estado), 1);
      @(negedge clock);
      check("bcd_estado_erro", int'(db_estado), 5);
      check("bcd_erro_alto", int'(erro), 1);
      check("bcd_echo_baixo", int'(echo), 0);
      trigger = 1'b0;
      repeat (5) @(negedge clock);
      check("bcd_erro_mantem", int'(erro), 1);
      check("bcd_estado_mantem", int'(db_estado), 5);
      run_pulse(4'd0, 4'd1, 4'd2, 12 * R, 1'b0, 3);
`else
      // Without the check, 0x00A counts down arithmetically as ten units.
      run_pulse(4'd0, 4'd0, 4'hA, 10 * R, 1'b0, 3);
      check("erro_fixo", int'(erro), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
